// File: rtl/ansi_colour_pkg.sv
// Shared types and constants for the ANSI SGR colour decoder.
package ansi_colour_pkg;

    // Text colour selected by SGR codes
    typedef enum logic [1:0] {
        WHITE  = 2'd0,
        BLUE   = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } colour_t;

    // Escape-sequence framing bytes
    localparam logic [7:0] ESC     = 8'h1B;
    localparam logic [7:0] CSI_LB  = 8'h5B;  // '['
    localparam logic [7:0] SEP     = 8'h3B;  // ';'
    localparam logic [7:0] SGR_END = 8'h6D;  // 'm'
    localparam logic [7:0] DIGIT_0 = 8'h30;
    localparam logic [7:0] DIGIT_9 = 8'h39;

    // Supported SGR parameter values
    localparam int unsigned SGR_RESET  = 0;
    localparam int unsigned SGR_WHITE  = 37;
    localparam int unsigned SGR_BLUE   = 94;
    localparam int unsigned SGR_YELLOW = 33;
    localparam int unsigned SGR_RED    = 31;

endpackage

// File: rtl/sgr_param_accum.sv
// Saturating decimal accumulator for SGR parameters plus the code-to-colour lookup.
// The lookup always reflects the currently held value; the caller decides when to apply it.
module sgr_param_accum
    import ansi_colour_pkg::*;
#(
    parameter int unsigned ACC_W = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       digit_en,
    input  logic [3:0] digit,
    output logic       known,
    output colour_t    colour
);

    // Wide enough that acc*10+9 never wraps before the saturation test
    localparam int unsigned SUM_W = ACC_W + 4;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum;
    logic [31:0]      acc_ext;

    // Next accumulator value: clear wins, otherwise shift in a decimal digit with saturation
    always_comb begin
        sum   = SUM_W'(acc_q) * SUM_W'(4'd10) + SUM_W'(digit);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (digit_en) begin
            acc_d = (sum > ACC_MAX) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_ext = 32'(acc_q);

    // Map the held parameter to a colour; anything unsupported is flagged as unknown
    always_comb begin
        known  = 1'b1;
        colour = WHITE;
        case (acc_ext)
            SGR_RESET, SGR_WHITE: colour = WHITE;
            SGR_BLUE:             colour = BLUE;
            SGR_YELLOW:           colour = YELLOW;
            SGR_RED:              colour = RED;
            default:              known  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ansi_colour_decoder.sv
// ANSI colourised text stream decoder: strips ESC[...m sequences and tags each text byte
// with the colour in effect. Optional saturating error counter enabled by the macro
// ANSI_COLOUR_DECODER_ERR_CNT_EN (adds the err_count port).
module ansi_colour_decoder
    import ansi_colour_pkg::*;
#(
    parameter int unsigned ACC_W = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [1:0] out_colour,
    input  logic       out_ready,
    output logic       seq_error,
    output logic       unknown_code
`ifdef ANSI_COLOUR_DECODER_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {
        StText,
        StEscSeen,
        StCsiParam
    } state_t;

    state_t     state_q, state_d;
    colour_t    colour_q;
    colour_t    out_colour_q;
    logic       out_valid_q;
    logic [7:0] out_data_q;
    logic       seq_error_q;
    logic       unknown_code_q;

    logic       accept;
    logic       emit;
    logic       seq_err;
    logic       apply;
    logic       acc_clear;
    logic       digit_en;
    logic       is_digit;
    logic       lut_known;
    colour_t    lut_colour;

    // A slot is free whenever the output register is empty or draining this cycle
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_digit = (in_data >= DIGIT_0) && (in_data <= DIGIT_9);

    sgr_param_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .digit_en (digit_en),
        .digit    (in_data[3:0]),
        .known    (lut_known),
        .colour   (lut_colour)
    );

    // Decode the accepted byte into a state transition and a set of actions
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        seq_err   = 1'b0;
        apply     = 1'b0;
        acc_clear = 1'b0;
        digit_en  = 1'b0;
        if (accept) begin
            case (state_q)
                StText: begin
                    if (in_data == ESC) begin
                        state_d = StEscSeen;
                    end else begin
                        emit = 1'b1;
                    end
                end
                StEscSeen: begin
                    if (in_data == CSI_LB) begin
                        state_d   = StCsiParam;
                        acc_clear = 1'b1;
                    end else begin
                        // Not a CSI: flag it and treat the byte as ordinary text
                        seq_err = 1'b1;
                        if (in_data == ESC) begin
                            state_d = StEscSeen;
                        end else begin
                            state_d = StText;
                            emit    = 1'b1;
                        end
                    end
                end
                StCsiParam: begin
                    if (is_digit) begin
                        digit_en = 1'b1;
                    end else if (in_data == SEP) begin
                        apply     = 1'b1;
                        acc_clear = 1'b1;
                    end else if (in_data == SGR_END) begin
                        apply   = 1'b1;
                        state_d = StText;
                    end else begin
                        // Malformed: drop the byte and abandon the pending parameter
                        seq_err = 1'b1;
                        state_d = StText;
                    end
                end
                default: state_d = StText;
            endcase
        end
    end

    // FSM state, current colour and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StText;
            colour_q       <= WHITE;
            out_valid_q    <= 1'b0;
            out_data_q     <= 8'h00;
            out_colour_q   <= WHITE;
            seq_error_q    <= 1'b0;
            unknown_code_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (apply && lut_known) begin
                colour_q <= lut_colour;
            end
            if (emit) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= in_data;
                out_colour_q <= colour_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            seq_error_q    <= seq_err;
            unknown_code_q <= apply && !lut_known;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_colour   = out_colour_q;
    assign seq_error    = seq_error_q;
    assign unknown_code = unknown_code_q;

`ifdef ANSI_COLOUR_DECODER_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        err_pulse_d;

    // Counts in step with the visible pulse, since both derive from the same decode
    assign err_pulse_d = seq_err || (apply && !lut_known);

    // Saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 16'h0000;
        end else if (err_pulse_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_count = err_cnt_q;
`else
    // Error counter not built
`endif

endmodule

// File: tb/tb_ansi_colour_decoder.sv
// Directed bench for ansi_colour_decoder with an output scoreboard and pulse counters.
module tb_ansi_colour_decoder;
    import ansi_colour_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_colour;
    logic       out_ready;
    logic       seq_error;
    logic       unknown_code;
`ifdef ANSI_COLOUR_DECODER_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int seq_cnt   = 0;
    int unk_cnt   = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_e;

    ansi_colour_decoder #(
        .ACC_W (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_colour   (out_colour),
        .out_ready    (out_ready),
        .seq_error    (seq_error),
        .unknown_code (unknown_code)
`ifdef ANSI_COLOUR_DECODER_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop and compare on each output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (seq_error) seq_cnt++;
            if (unknown_code) unk_cnt++;
            if (out_valid && out_ready) begin
                n_asserts++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_output got %0h expected none", out_data);
                end
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    n_asserts++;
                    assert ({out_data, out_colour} === exp_e) else begin
                        n_fail++;
                        $error("FAIL out_byte got %0h/%0d expected %0h/%0d",
                               out_data, out_colour, exp_e[9:2], exp_e[1:0]);
                    end
                end
            end
        end
    end

    task automatic expect_b(input logic [7:0] b, input colour_t c);
        exp_q.push_back({b, c});
    endtask

    // Present one byte and hold it until accepted; time stays at posedge+1
    task automatic send(input logic [7:0] b);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout byte %0h never accepted", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_scn(input string tag, input int exp_seq, input int exp_unk);
        idle(4);
        @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_seq_error"}, seq_cnt, exp_seq);
        check({tag, "_unknown_code"}, unk_cnt, exp_unk);
        @(posedge clk);
        #1;
        seq_cnt = 0;
        unk_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_colour", out_colour, WHITE);
        check("rst_seq_error", seq_error, 0);
        check("rst_unknown_code", unknown_code, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Basic colour switch
        expect_b("A", WHITE);
        expect_b("B", BLUE);
        send("A");
        send(ESC);
        send_str("[94m");
        send("B");
        end_scn("blue", 0, 0);

        // Multiple parameters, last one wins
        expect_b("x", YELLOW);
        send(ESC);
        send_str("[31;0;33m");
        send("x");
        end_scn("multi", 0, 0);

        // Empty parameters act as 0
        expect_b("r", RED);
        expect_b("w", WHITE);
        send(ESC);
        send_str("[;31m");
        send("r");
        send(ESC);
        send_str("[m");
        send("w");
        end_scn("empty", 0, 0);

        // ESC not followed by '[' is re-processed as text
        expect_b("Q", WHITE);
        send(ESC);
        send("Q");
        end_scn("esc_q", 1, 0);

        // Bad byte in parameters: dropped, pending 31 not applied
        expect_b("k", WHITE);
        send(ESC);
        send_str("[31x");
        send("k");
        end_scn("csi_bad", 1, 0);

        // Saturated parameter is unknown and leaves colour alone
        do_reset();
        expect_b("c", BLUE);
        send(ESC);
        send_str("[94m");
        send(ESC);
        send_str("[999m");
        send("c");
        end_scn("saturate", 0, 1);
`ifdef ANSI_COLOUR_DECODER_ERR_CNT_EN
        @(negedge clk);
        check("err_count", err_count, 1);
        @(posedge clk);
        #1;
`endif

        // Backpressure: output held, nothing lost or duplicated
        expect_b("a", BLUE);
        expect_b("b", BLUE);
        expect_b("c", BLUE);
        out_ready = 1'b0;
        send("a");
        in_valid = 1'b1;
        in_data  = "b";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, "a");
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send("b");
        send("c");
        end_scn("stall", 0, 0);

        // Reset mid-sequence, with a simultaneous input byte that must be ignored
        send(ESC);
        send_str("[9");
        in_valid = 1'b1;
        in_data  = "q";
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_priority_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        expect_b("3", WHITE);
        expect_b("m", WHITE);
        expect_b("z", WHITE);
        send_str("3mz");
        end_scn("mid_rst", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
